uart: RTL and testbench
=======================

// Module: uart
// PURPOSE
//  Transmit-only UART (8N1 by default). Serialises one byte per start_send request.
//  Frame order: start bit, 8 data bits LSB first, stop bit; each bit lasts
//  CLK_PER_BAUD clocks.
//  Sits between on-chip byte producers and the board TX pin. done reports frame completion.
// PARAMETERS
//  CLK_PER_BAUD  default 4  clocks per bit period; legal range >= 2
// PORTS
//  clk         in   1  single system clock, rising edge
//  rst         in   1  synchronous, active-low reset (0 = reset)
//  tx_byte     in   8  byte to send; sampled only when a frame is accepted
//  start_send  in   1  level request; a new frame is accepted whenever FSM is IDLE and this is 1
//  tx          out  1  serial line, registered, idle high
//  done        out  1  one-clock pulse after the stop bit completes
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state=IDLE, tx=1, done=0, bit/baud counters=0.
//    Reset is honoured mid-frame: the frame is aborted, tx returns to 1 on that edge, no done.
//  - FSM states: IDLE, START, DATA, [PARITY], STOP.
//  - IDLE:
//    - tx=1.
//    - If start_send==1: latch tx_byte into shift reg and go to START. tx=0 from the next cycle,
//      i.e. 1 clk latency from request to line.
//  - START: tx=0 for CLK_PER_BAUD clks, then DATA.
//  - DATA: tx=shift[0] for CLK_PER_BAUD clks per bit, shift right, bit index 0..7, then STOP
//    (or PARITY).
//  - STOP: tx=1 for CLK_PER_BAUD clks, then IDLE with done=1 for exactly that first IDLE cycle.
//  - done is registered and is 0 in all other cycles.
//  - start_send held high: the IDLE/done cycle also accepts the next byte.
//    Frame period = 10*CLK_PER_BAUD+1 clks (11*CLK_PER_BAUD+1 with parity).
//    Exactly one idle-high cycle between frames.
//  - tx_byte changes during a frame have no effect on the frame in flight.
//  - start_send asserted outside IDLE is ignored (no queueing).
//  - Baud counter: counts 0..CLK_PER_BAUD-1, width $clog2(CLK_PER_BAUD).
//    Wraps to 0 on each bit boundary; cleared on accept.
// CONFIGURATION
//  - UART_PARITY_EN defined: a PARITY state is inserted between DATA and STOP.
//    - It transmits the even-parity bit (^data) for CLK_PER_BAUD clks.
//    - Frame becomes 11 bits.
//  - Undefined: 8N1 exactly as above; no PARITY state or logic is present.
// STRUCTURE
//  - Package uart_pkg:
//    - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
//    - localparam DATA_BITS = 8
//  - Sub-module uart_baud_gen (CLK_PER_BAUD):
//    - outputs a one-clk tick at the last clock of each bit period.
//    - Inputs: clk, rst, clear (held clear in IDLE).
//  - uart instantiates uart_baud_gen plus the FSM, shift register and bit counter.
// TESTING
//  1. rst=0 for 3 clks -> tx=1, done=0 every cycle; release with start_send=0 -> tx stays 1.
//  2. CLK_PER_BAUD=4, tx_byte=8'h30, one-clk start_send pulse.
//     -> tx from next clk: 0x4 (start), then bits 0,0,0,0,1,1,0,0 each x4, then 1x4 (stop).
//     -> done=1 at clk 41 only.
//  3. start_send held at 1, tx_byte=8'h30 -> frames repeat every 41 clks.
//     -> one tx=1 cycle, coinciding with done, between a stop bit and the next start bit.
//  4. Change tx_byte 8'h30->8'hFF mid-frame -> current frame still sends 8'h30.
//     -> the next accepted frame sends 8'hFF.
//  5. rst=0 during DATA bit 3 -> tx=1, done=0 next edge.
//     -> after release with start_send=1, a full clean frame follows.
//  6. UART_PARITY_EN, tx_byte=8'h07 -> parity bit 1 after data, stop follows.
//     -> done at clk 45 (CLK_PER_BAUD=4).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the transmit-only UART.
// Optional even parity is enabled by defining UART_PARITY_EN.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick is high on the last clock of each bit period.
// Held at zero while clear is high so every frame starts on a fresh period.
module uart_baud_gen #(
  parameter int CLK_PER_BAUD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BAUD - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = !clear && (r_cnt == LAST);
endmodule

// File: rtl/uart.sv
// Transmit-only UART, 8N1 by default; define UART_PARITY_EN to append an
// even-parity bit after the data bits (8E1).
module uart
  import uart_pkg::*;
#(
  parameter int CLK_PER_BAUD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_byte,
  input  logic                 start_send,
  output logic                 tx,
  output logic                 done
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_tx_state_t       r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [BW-1:0]        r_bit, w_bit_next;
  logic                 r_tx, w_tx_next;
  logic                 r_done, w_done_next;
  logic                 w_tick;
  logic                 w_baud_clear;
`ifdef UART_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  assign w_baud_clear = (r_state == IDLE);

  uart_baud_gen #(.CLK_PER_BAUD(CLK_PER_BAUD)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_baud_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_bit   <= w_bit_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
`ifdef UART_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  // tx is registered, so each branch computes the line level of the next state.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_tx_next    = r_tx;
    w_done_next  = 1'b0;
`ifdef UART_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (start_send) begin
          w_state_next = START;
          w_shift_next = tx_byte;
          w_bit_next   = '0;
          w_tx_next    = 1'b0;
`ifdef UART_PARITY_EN
          w_parity_next = ^tx_byte;
`endif
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            w_state_next = PARITY;
            w_tx_next    = r_parity;
`else
            w_state_next = STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            w_bit_next   = r_bit + BW'(1);
            w_shift_next = r_shift >> 1;
            w_tx_next    = r_shift[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_state_next = STOP;
          w_tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          w_state_next = IDLE;
          w_tx_next    = 1'b1;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign tx   = r_tx;
  assign done = r_done;
endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: accepted bytes are queued by a frame-level
// model, and a line monitor decodes tx/done and checks them against the queue.
module tb_uart;
  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int L = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_send = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx;
  logic       done;

  uart #(.CLK_PER_BAUD(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_byte    (tx_byte),
    .start_send (start_send),
    .tx         (tx),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   busy = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   mon_s = 0;
  int   mon_exp_done = -1;
  bit   mon_in_f = 1'b0;
  logic mon_smp [L];
  logic [7:0] dir_bytes [2] = '{8'h30, 8'h07};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: a frame occupies L clocks after acceptance, and the
  // following clock is the idle/done clock in which the next request is taken.
  initial forever begin
    exp_t e;
    @(posedge clk);
    cyc++;
    if (rst === 1'b0) begin
      busy = 0;
      exp_q.delete();
    end else if (busy == 0 && start_send === 1'b1) begin
      e.b = tx_byte;
      e.c = cyc;
      exp_q.push_back(e);
      busy = L;
    end else if (busy > 0) begin
      busy--;
    end
  end

  task automatic check_frame(input int s);
    logic [7:0] d;
    logic       steady;
    exp_t       e;
    steady = 1'b1;
    for (int j = 0; j < NB; j++)
      for (int k = 1; k < CPB; k++)
        if (mon_smp[j*CPB+k] !== mon_smp[j*CPB]) steady = 1'b0;
    for (int j = 0; j < 8; j++) d[j] = mon_smp[(j+1)*CPB];
    chk("bit_steady", 32'(steady), 32'd1);
    chk("stop_bit", 32'(mon_smp[(NB-1)*CPB]), 32'd1);
    if (exp_q.size() == 0) begin
      chk("unexpected_frame", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("frame_data", 32'(d), 32'(e.b));
      chk("frame_start_cycle", s, e.c);
`ifdef UART_PARITY_EN
      chk("parity_bit", 32'(mon_smp[9*CPB]), 32'(^e.b));
`endif
    end
  endtask

  // Line monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("done_pulse", 32'(done), 32'(cyc == mon_exp_done));
      if (cyc == mon_exp_done) chk("tx_idle_at_done", 32'(tx), 32'd1);
      if (mon_in_f) begin
        mon_smp[cyc - mon_s] = tx;
        if (cyc - mon_s == L - 1) begin
          mon_in_f = 1'b0;
          mon_exp_done = cyc + 1;
          check_frame(mon_s);
        end
      end else if (tx === 1'b0) begin
        mon_in_f = 1'b1;
        mon_s = cyc;
        mon_smp[0] = tx;
      end
      if (rst === 1'b0) begin
        mon_in_f = 1'b0;
        if (mon_exp_done > cyc) mon_exp_done = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int k = 0; k < 4*L; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        c = cyc;
        break;
      end
    end
    chk("done_seen", 32'(c >= 0), 32'd1);
  endtask

  initial begin
    int c0, d1, d2, d3, dc, mode;

    repeat (3) begin
      @(negedge clk);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_done", 32'(done), 32'd0);
    end
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
    end

    for (int i = 0; i < 2; i++) begin
      tick();
      tx_byte = dir_bytes[i];
      start_send = 1'b1;
      c0 = cyc;
      tick();
      start_send = 1'b0;
      wait_done(dc);
      chk("done_latency", dc - c0, L + 1);
      $display("[TB] single frame %02h: done %0d clocks after request", dir_bytes[i], dc - c0);
    end

    tick();
    tx_byte = 8'h30;
    start_send = 1'b1;
    wait_done(d1);
    repeat (20) tick();
    tx_byte = 8'hFF;
    wait_done(d2);
    chk("frame_period", d2 - d1, L + 1);
    wait_done(d3);
    start_send = 1'b0;
    chk("frame_period", d3 - d2, L + 1);
    $display("[TB] back-to-back frames: periods %0d and %0d", d2 - d1, d3 - d2);

    tick();
    tx_byte = 8'hA5;
    start_send = 1'b1;
    tick();
    start_send = 1'b0;
    repeat (17) tick();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b1;
    tx_byte = 8'h3C;
    start_send = 1'b1;
    c0 = cyc;
    wait_done(dc);
    start_send = 1'b0;
    chk("post_reset_latency", dc - c0, L + 1);
    $display("[TB] reset during data bit 3, recovery frame done after %0d clocks", dc - c0);

    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 9);
      tick();
      tx_byte = 8'($urandom);
      if (mode == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b1;
      end else if (mode < 5) begin
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
      end else begin
        start_send = 1'b1;
        repeat ($urandom_range(1, 2*L)) begin
          tick();
          tx_byte = 8'($urandom);
        end
        start_send = 1'b0;
      end
      repeat ($urandom_range(0, L + 10)) tick();
      $display("[TB] random step %0d mode %0d, %0d frames pending", it, mode, exp_q.size());
    end

    start_send = 1'b0;
    for (int k = 0; k < 3*L; k++) begin
      tick();
      if (exp_q.size() == 0 && busy == 0) break;
    end
    repeat (3) tick();
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
